// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahb_pkg
// Brief   : Shared AHB encodings, default-slave state enum and region slice.
// Rev     : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int REGION_MSB = 31;
    localparam int REGION_LSB = 28;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dflt_state_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no data.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// Module  : ahb_default_slave
// Brief   : Two-cycle ERROR responder for unmapped NONSEQ/SEQ transfers.
// Rev     : 1.0 - initial release
// ============================================================================
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hready,
    input  logic [1:0] htrans,
    input  logic       unmapped,
    output logic       dflt_hreadyout,
    output logic       dflt_hresp
);

    dflt_state_t r_state;
    dflt_state_t w_state_next;
    logic        w_err_req;

    assign w_err_req = hready && unmapped && htrans_active(htrans);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= DS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DS_IDLE: w_state_next = w_err_req ? DS_ERR1 : DS_IDLE;
            DS_ERR1: w_state_next = DS_ERR2;
            DS_ERR2: w_state_next = w_err_req ? DS_ERR1 : DS_IDLE;
            default: w_state_next = DS_IDLE;
        endcase
    end

    always_comb begin
        dflt_hreadyout = 1'b1;
        dflt_hresp     = HRESP_OKAY;
        case (r_state)
            DS_ERR1: begin
                dflt_hreadyout = 1'b0;
                dflt_hresp     = HRESP_ERROR;
            end
            DS_ERR2: begin
                dflt_hreadyout = 1'b1;
                dflt_hresp     = HRESP_ERROR;
            end
            default: begin
                dflt_hreadyout = 1'b1;
                dflt_hresp     = HRESP_OKAY;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ahb_decoder.sv
`default_nettype none
// ============================================================================
// Module  : ahb_decoder
// Brief   : AHB address decoder with data-phase select register. Define
//           AHB_DEFAULT_SLAVE_EN to include the built-in ERROR default slave.
// Rev     : 1.0 - initial release
// ============================================================================
module ahb_decoder
    import ahb_pkg::*;
#(
    parameter logic [3:0] SLV1_REGION = 4'h0,
    parameter logic [3:0] SLV2_REGION = 4'h1,
    parameter logic [3:0] SLV3_REGION = 4'h2,
    parameter logic [3:0] SLV4_REGION = 4'h3
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hready,
    output logic        hsel_1,
    output logic        hsel_2,
    output logic        hsel_3,
    output logic        hsel_4,
    output logic [1:0]  sel,
    output logic        dflt_active,
    output logic        dflt_hreadyout,
    output logic        dflt_hresp
);

    logic [3:0] w_region;
    logic       w_hit1;
    logic       w_hit2;
    logic       w_hit3;
    logic       w_hit4;
    logic       w_unmapped;
    logic [1:0] w_index;
    logic [1:0] r_sel;

    assign w_region = haddr[REGION_MSB:REGION_LSB];

    // Overlapping regions resolve to the lowest slave index.
    assign w_hit1     = (w_region == SLV1_REGION);
    assign w_hit2     = (w_region == SLV2_REGION) && !w_hit1;
    assign w_hit3     = (w_region == SLV3_REGION) && !w_hit1 && !w_hit2;
    assign w_hit4     = (w_region == SLV4_REGION) && !w_hit1 && !w_hit2 && !w_hit3;
    assign w_unmapped = !(w_hit1 || w_hit2 || w_hit3 || w_hit4);

    always_comb begin
        w_index = 2'b00;
        if (w_hit2) w_index = 2'b01;
        if (w_hit3) w_index = 2'b10;
        if (w_hit4) w_index = 2'b11;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_sel <= 2'b00;
        end else if (hready) begin
            r_sel <= w_index;
        end
    end

    assign sel    = r_sel;
    assign hsel_2 = w_hit2;
    assign hsel_3 = w_hit3;
    assign hsel_4 = w_hit4;

`ifdef AHB_DEFAULT_SLAVE_EN
    logic r_dflt_active;
    logic w_unused_addr;

    assign w_unused_addr = ^haddr[REGION_LSB-1:0];
    assign hsel_1        = w_hit1;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_dflt_active <= 1'b0;
        end else if (hready) begin
            r_dflt_active <= w_unmapped;
        end
    end

    assign dflt_active = r_dflt_active;

    ahb_default_slave u_default_slave (
        .hclk           (hclk),
        .hreset         (hreset),
        .hready         (hready),
        .htrans         (htrans),
        .unmapped       (w_unmapped),
        .dflt_hreadyout (dflt_hreadyout),
        .dflt_hresp     (dflt_hresp)
    );
`else
    logic w_unused_addr;

    // Without a default slave, unmapped space aliases onto slave 1.
    assign w_unused_addr  = ^{haddr[REGION_LSB-1:0], htrans};
    assign hsel_1         = w_hit1 || w_unmapped;
    assign dflt_active    = 1'b0;
    assign dflt_hreadyout = 1'b1;
    assign dflt_hresp     = HRESP_OKAY;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_decoder
// Brief   : Self-checking bench for ahb_decoder with a select-register scoreboard.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ahb_decoder;

    logic        hclk;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic        hsel_1;
    logic        hsel_2;
    logic        hsel_3;
    logic        hsel_4;
    logic [1:0]  sel;
    logic        dflt_active;
    logic        dflt_hreadyout;
    logic        dflt_hresp;
    logic [3:0]  hsel_v;

    typedef struct packed {
        logic       active;
        logic [1:0] sel;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks;
    int   n_fail;

    assign hsel_v = {hsel_4, hsel_3, hsel_2, hsel_1};

    ahb_decoder #(
        .SLV1_REGION (4'h0),
        .SLV2_REGION (4'h1),
        .SLV3_REGION (4'h2),
        .SLV4_REGION (4'h3)
    ) dut (
        .hclk           (hclk),
        .hreset         (hreset),
        .haddr          (haddr),
        .htrans         (htrans),
        .hready         (hready),
        .hsel_1         (hsel_1),
        .hsel_2         (hsel_2),
        .hsel_3         (hsel_3),
        .hsel_4         (hsel_4),
        .sel            (sel),
        .dflt_active    (dflt_active),
        .dflt_hreadyout (dflt_hreadyout),
        .dflt_hresp     (dflt_hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic exp_t model(input logic [31:0] a);
        exp_t       e;
        logic [3:0] r;
        r        = a[31:28];
        e.active = 1'b0;
        e.sel    = 2'b00;
        case (r)
            4'h0:    e.sel = 2'b00;
            4'h1:    e.sel = 2'b01;
            4'h2:    e.sel = 2'b10;
            4'h3:    e.sel = 2'b11;
`ifdef AHB_DEFAULT_SLAVE_EN
            default: e.active = 1'b1;
`else
            default: e.active = 1'b0;
`endif
        endcase
        return e;
    endfunction

    function automatic logic [3:0] model_hsel(input logic [31:0] a);
        logic [3:0] r;
        r = a[31:28];
        case (r)
            4'h0:    return 4'b0001;
            4'h1:    return 4'b0010;
            4'h2:    return 4'b0100;
            4'h3:    return 4'b1000;
`ifdef AHB_DEFAULT_SLAVE_EN
            default: return 4'b0000;
`else
            default: return 4'b0001;
`endif
        endcase
    endfunction

    // Drive one address phase; a sampled (hready=1) phase queues its expectation.
    task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
        haddr  = a;
        htrans = t;
        hready = r;
        if (r) sb.push_back(model(a));
        #1;
    endtask

    task automatic cycle();
        @(posedge hclk);
        #1;
        if (sb.size() > 0) cur = sb.pop_front();
    endtask

    task automatic release_reset();
        @(posedge hclk);
        #1;
        hreset = 1'b0;
        sb.delete();
        cur = '0;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        haddr  = 32'h2000_0000;
        htrans = 2'b00;
        hready = 1'b1;
        #2;
        n_checks++; if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel got=%b exp=00", sel); end
        n_checks++; if (dflt_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", dflt_active); end
        n_checks++; if (dflt_hreadyout !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout got=%b exp=1", dflt_hreadyout); end
        n_checks++; if (dflt_hresp !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got=%b exp=0", dflt_hresp); end
        n_checks++; if (hsel_v !== 4'b0100) begin n_fail++; $display("FAIL reset_hsel got=%b exp=0100", hsel_v); end
        release_reset();
    endtask

    task automatic test_decode();
        logic [31:0] addrs [4];
        addrs = '{32'h0000_0010, 32'h1000_0010, 32'h2000_0010, 32'h3000_0010};
        for (int i = 0; i < 4; i++) begin
            drive(addrs[i], 2'b10, 1'b1);
            n_checks++;
            if (hsel_v !== model_hsel(addrs[i])) begin
                n_fail++; $display("FAIL decode_hsel addr=%h got=%b exp=%b", addrs[i], hsel_v, model_hsel(addrs[i]));
            end
            cycle();
            n_checks++;
            if (sel !== cur.sel) begin
                n_fail++; $display("FAIL decode_sel addr=%h got=%b exp=%b", addrs[i], sel, cur.sel);
            end
        end
        n_checks++;
        if (cur.sel !== 2'b11) begin n_fail++; $display("FAIL decode_last_model got=%b exp=11", cur.sel); end
    endtask

    task automatic test_wait_hold();
        drive(32'h1000_0000, 2'b10, 1'b1);
        cycle();
        n_checks++; if (sel !== cur.sel) begin n_fail++; $display("FAIL wait_first got=%b exp=%b", sel, cur.sel); end
        for (int i = 0; i < 3; i++) begin
            drive(32'h3000_0000, 2'b10, 1'b0);
            cycle();
            n_checks++;
            if (sel !== 2'b01) begin n_fail++; $display("FAIL wait_hold cyc=%0d got=%b exp=01", i, sel); end
        end
        drive(32'h3000_0000, 2'b10, 1'b1);
        cycle();
        n_checks++; if (sel !== 2'b11) begin n_fail++; $display("FAIL wait_release got=%b exp=11", sel); end
    endtask

    task automatic test_unmapped_nonseq();
        drive(32'h8000_0000, 2'b10, 1'b1);
        n_checks++;
        if (hsel_v !== model_hsel(32'h8000_0000)) begin
            n_fail++; $display("FAIL unmapped_hsel got=%b exp=%b", hsel_v, model_hsel(32'h8000_0000));
        end
        cycle();
        n_checks++; if (sel !== cur.sel) begin n_fail++; $display("FAIL unmapped_sel got=%b exp=%b", sel, cur.sel); end
        n_checks++; if (dflt_active !== cur.active) begin n_fail++; $display("FAIL unmapped_active got=%b exp=%b", dflt_active, cur.active); end
`ifdef AHB_DEFAULT_SLAVE_EN
        n_checks++; if (dflt_hreadyout !== 1'b0) begin n_fail++; $display("FAIL err1_hreadyout got=%b exp=0", dflt_hreadyout); end
        n_checks++; if (dflt_hresp !== 1'b1) begin n_fail++; $display("FAIL err1_hresp got=%b exp=1", dflt_hresp); end
        drive(32'h0000_0000, 2'b00, 1'b0);
        cycle();
        n_checks++; if (dflt_hreadyout !== 1'b1) begin n_fail++; $display("FAIL err2_hreadyout got=%b exp=1", dflt_hreadyout); end
        n_checks++; if (dflt_hresp !== 1'b1) begin n_fail++; $display("FAIL err2_hresp got=%b exp=1", dflt_hresp); end
        n_checks++; if (dflt_active !== 1'b1) begin n_fail++; $display("FAIL err2_active got=%b exp=1", dflt_active); end
        drive(32'h0000_0000, 2'b00, 1'b1);
        cycle();
        n_checks++; if (dflt_hresp !== 1'b0) begin n_fail++; $display("FAIL after_err_hresp got=%b exp=0", dflt_hresp); end
        n_checks++; if (dflt_active !== cur.active) begin n_fail++; $display("FAIL after_err_active got=%b exp=%b", dflt_active, cur.active); end
`else
        n_checks++; if (dflt_hreadyout !== 1'b1) begin n_fail++; $display("FAIL alias_hreadyout got=%b exp=1", dflt_hreadyout); end
        n_checks++; if (dflt_hresp !== 1'b0) begin n_fail++; $display("FAIL alias_hresp got=%b exp=0", dflt_hresp); end
`endif
    endtask

    task automatic test_unmapped_idle();
        drive(32'h8000_0000, 2'b00, 1'b1);
        cycle();
        n_checks++; if (dflt_active !== cur.active) begin n_fail++; $display("FAIL idle_active got=%b exp=%b", dflt_active, cur.active); end
        n_checks++; if (dflt_hreadyout !== 1'b1) begin n_fail++; $display("FAIL idle_hreadyout got=%b exp=1", dflt_hreadyout); end
        n_checks++; if (dflt_hresp !== 1'b0) begin n_fail++; $display("FAIL idle_hresp got=%b exp=0", dflt_hresp); end
        drive(32'h0000_0000, 2'b00, 1'b1);
        cycle();
    endtask

    task automatic test_back_to_back();
`ifdef AHB_DEFAULT_SLAVE_EN
        drive(32'h9000_0000, 2'b10, 1'b1);
        cycle();
        n_checks++; if (dflt_hreadyout !== 1'b0) begin n_fail++; $display("FAIL b2b_err1a got=%b exp=0", dflt_hreadyout); end
        drive(32'hA000_0000, 2'b11, 1'b0);
        cycle();
        n_checks++; if ({dflt_hreadyout, dflt_hresp} !== 2'b11) begin n_fail++; $display("FAIL b2b_err2a got=%b exp=11", {dflt_hreadyout, dflt_hresp}); end
        drive(32'hA000_0000, 2'b11, 1'b1);
        cycle();
        n_checks++; if ({dflt_hreadyout, dflt_hresp} !== 2'b01) begin n_fail++; $display("FAIL b2b_err1b got=%b exp=01", {dflt_hreadyout, dflt_hresp}); end
        drive(32'h2000_0000, 2'b10, 1'b0);
        cycle();
        n_checks++; if ({dflt_hreadyout, dflt_hresp} !== 2'b11) begin n_fail++; $display("FAIL b2b_err2b got=%b exp=11", {dflt_hreadyout, dflt_hresp}); end
        drive(32'h2000_0000, 2'b10, 1'b1);
        cycle();
        n_checks++; if ({dflt_hreadyout, dflt_hresp} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle got=%b exp=10", {dflt_hreadyout, dflt_hresp}); end
        n_checks++; if ({dflt_active, sel} !== {cur.active, cur.sel}) begin n_fail++; $display("FAIL b2b_sel got=%b exp=%b", {dflt_active, sel}, {cur.active, cur.sel}); end
`else
        drive(32'h9000_0000, 2'b10, 1'b1);
        cycle();
        drive(32'h2000_0000, 2'b11, 1'b1);
        cycle();
        n_checks++; if (sel !== cur.sel) begin n_fail++; $display("FAIL b2b_sel got=%b exp=%b", sel, cur.sel); end
`endif
    endtask

    task automatic test_reset_mid_error();
`ifdef AHB_DEFAULT_SLAVE_EN
        drive(32'h8000_0000, 2'b10, 1'b1);
        cycle();
        n_checks++; if (dflt_hreadyout !== 1'b0) begin n_fail++; $display("FAIL mid_pre_hreadyout got=%b exp=0", dflt_hreadyout); end
`else
        drive(32'h3000_0000, 2'b10, 1'b1);
        cycle();
        n_checks++; if (sel !== 2'b11) begin n_fail++; $display("FAIL mid_pre_sel got=%b exp=11", sel); end
`endif
        #2;
        hreset = 1'b1;
        #1;
        n_checks++; if (dflt_hreadyout !== 1'b1) begin n_fail++; $display("FAIL mid_hreadyout got=%b exp=1", dflt_hreadyout); end
        n_checks++; if (dflt_hresp !== 1'b0) begin n_fail++; $display("FAIL mid_hresp got=%b exp=0", dflt_hresp); end
        n_checks++; if (dflt_active !== 1'b0) begin n_fail++; $display("FAIL mid_active got=%b exp=0", dflt_active); end
        n_checks++; if (sel !== 2'b00) begin n_fail++; $display("FAIL mid_sel got=%b exp=00", sel); end
        release_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cur      = '0;
        test_reset();
        test_decode();
        test_wait_hold();
        test_unmapped_nonseq();
        test_unmapped_idle();
        test_back_to_back();
        test_reset_mid_error();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_decoder.md
# ahb_decoder

Address-phase decoder and data-phase select register for the AHB interconnect, the master-to-slave counterpart of the read-data `Multiplexor`. It decodes `haddr` into one-hot `hsel_1..hsel_4` for the four slaves. It registers the decoded index as `sel[1:0]`, which steers the `Multiplexor` during the data phase. An optional built-in default slave answers unmapped addresses with a two-cycle ERROR response.

## Interface
- `SLV1_REGION`, default 4'h0: `haddr[31:28]` value that selects slave 1.
- `SLV2_REGION`, default 4'h1: region for slave 2.
- `SLV3_REGION`, default 4'h2: region for slave 3.
- `SLV4_REGION`, default 4'h3: region for slave 4.
- `hclk`  in  1: the single clock; all state updates on the rising edge.
- `hreset`  in  1: reset, asynchronous and active-high.
- `haddr`  in  32: address-phase address from the master.
- `htrans`  in  2: transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `hready`  in  1: global HREADY, i.e. the `Multiplexor` `hreadyout` after the default-slave merge.
- `hsel_1`..`hsel_4`  out  1 each: combinational one-hot slave selects.
- `sel`  out  2: registered data-phase slave index for the `Multiplexor`.
- `dflt_active`  out  1: the default slave owns the current data phase; the top level then takes `hreadyout`/`hresp` from it.
- `dflt_hreadyout`  out  1: default-slave HREADYOUT.
- `dflt_hresp`  out  1: default-slave HRESP; 0=OKAY, 1=ERROR.

## Operation
- **Decode (combinational):**
  - `hsel_n` = 1 when `haddr[31:28]` == `SLVn_REGION`.
  - Select is independent of `htrans`; slaves qualify the transfer themselves.
  - At most one `hsel_n` is high. Overlapping regions are a configuration error; lowest index wins.
- **Unmapped address:** all four `hsel_n` = 0; the default slave is targeted.
- **Select register:**
  - When `hready`=1 at the clock edge, `sel` loads the decoded index (slave 1→00 … slave 4→11), and `dflt_active` loads "unmapped".
  - When `hready`=0, both hold.
  - An unmapped address loads `sel`=00 (don't-care while `dflt_active`=1).
- **Default slave FSM**, states IDLE, ERR1, ERR2:
  - IDLE: `dflt_hreadyout`=1, `dflt_hresp`=0.
    - Go to ERR1 when `hready`=1, the address is unmapped and `htrans` is NONSEQ or SEQ.
    - An unmapped IDLE or BUSY transfer stays in IDLE and gets a zero-wait OKAY.
  - ERR1: `dflt_hreadyout`=0, `dflt_hresp`=1. Always go to ERR2.
  - ERR2: `dflt_hreadyout`=1, `dflt_hresp`=1.
    - Go to ERR1 if another unmapped NONSEQ/SEQ is sampled with `hready`=1.
    - Otherwise go to IDLE.
- The master may replace its next address after ERR1. Whatever address is present in the ERR2 cycle is decoded and registered normally.

## Timing
- `hsel_n`: zero latency from `haddr`.
- `sel`, `dflt_active`: valid from the cycle after the address-phase edge where `hready`=1; one-cycle latency.
- ERROR response: exactly two data-phase cycles; the first has HREADY low, the second high.
- Reset, asynchronous, takes effect immediately:
  - `sel`=00, `dflt_active`=0, FSM=IDLE.
  - Hence `dflt_hreadyout`=1 and `dflt_hresp`=0.
  - `hsel_n` follow `haddr` even in reset.
- Reset asserted mid-ERROR: the FSM returns to IDLE; the response is abandoned.
- Back-to-back unmapped transfers: ERR2 → ERR1 with no IDLE cycle in between.
- Wait states from a real slave (`hready`=0): `sel` is frozen, and a pending unmapped address is not sampled.

## Configuration
- `AHB_DEFAULT_SLAVE_EN` defined:
  - The default slave and FSM are present, as described above.
- `AHB_DEFAULT_SLAVE_EN` undefined:
  - The FSM is removed.
  - Unmapped addresses alias to slave 1: `hsel_1`=1, `sel`=00.
  - `dflt_active` tied 0, `dflt_hreadyout` tied 1, `dflt_hresp` tied 0.

## Structure
- Shared package `ahb_pkg`:
  - HTRANS encodings (`HTRANS_IDLE/BUSY/NONSEQ/SEQ`).
  - HRESP codes (`HRESP_OKAY/ERROR`).
  - Default-slave state enum.
  - Region-field slice constants (bits 31:28).
- One sub-module, `ahb_default_slave`, holds the FSM. Its inputs are `hclk`, `hreset`, `hready`, `htrans` and an unmapped flag; its outputs are `dflt_hreadyout` and `dflt_hresp`. It is instantiated only under `AHB_DEFAULT_SLAVE_EN`.

## Test plan
- **Reset:** assert `hreset` with `haddr`=32'h2000_0000 → `sel`=00, `dflt_active`=0, `dflt_hreadyout`=1, `dflt_hresp`=0, `hsel_3`=1.
- **Sequential decode:** `haddr`=0x0000_0010, 0x1000_0010, 0x2000_0010, 0x3000_0010 with NONSEQ and `hready`=1 each cycle → `hsel` one-hot in the same cycle; `sel`=00, 01, 10, 11 one cycle later.
- **Wait-state hold:** `haddr`=0x1000_0000 sampled, then `hready`=0 for 3 cycles while `haddr`=0x3000_0000 → `sel` stays 01 for all 3 cycles, then becomes 11 after `hready` returns to 1.
- **Unmapped NONSEQ:** `haddr`=0x8000_0000 NONSEQ with `hready`=1 →
  - next cycle: `dflt_active`=1, `dflt_hreadyout`=0, `dflt_hresp`=1;
  - following cycle: `dflt_hreadyout`=1, `dflt_hresp`=1;
  - then IDLE.
- **Unmapped IDLE transfer:** `haddr`=0x8000_0000 with `htrans`=IDLE → `dflt_active`=1, `dflt_hreadyout`=1, `dflt_hresp`=0 (zero-wait OKAY).
- **Reset mid-error:** assert `hreset` during ERR1 → outputs return to `dflt_hreadyout`=1, `dflt_hresp`=0 immediately. With the macro undefined, `haddr`=0x8000_0000 → `hsel_1`=1, `sel`=00.
